// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types for the audio output arbiter
package audio_pkg;

  localparam int SAMPLE_W = 24;

  typedef struct packed {
    logic [SAMPLE_W-1:0] right;
    logic [SAMPLE_W-1:0] left;
  } stereo_frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_e;

endpackage

// File: rtl/audio_rr_pick.sv
// rtl/audio_rr_pick.sv - combinational rotating-priority picker
module audio_rr_pick #(
  parameter int NUM_REQ_P = 3,
  parameter int IDX_W_P   = (NUM_REQ_P > 1) ? $clog2(NUM_REQ_P) : 1
) (
  input  logic [NUM_REQ_P-1:0] valid_i,
  input  logic [IDX_W_P-1:0]   ptr_i,
  output logic                 any_o,
  output logic [IDX_W_P-1:0]   winner_o,
  output logic [NUM_REQ_P-1:0] onehot_o
);

  always_comb begin
    int  idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    winner_o = '0;
    onehot_o = '0;
    // Scan from the pointer upward, wrapping, and keep the first hit.
    for (int k = 0; k < NUM_REQ_P; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ_P) idx = idx - NUM_REQ_P;
      if (!found && valid_i[IDX_W_P'(idx)]) begin
        found    = 1'b1;
        winner_o = IDX_W_P'(idx);
      end
    end
    any_o = found;
    if (found) onehot_o[winner_o] = 1'b1;
  end

endmodule

// File: rtl/audio_out_arbiter.sv
// rtl/audio_out_arbiter.sv - round-robin frame arbiter with silence injection
module audio_out_arbiter
  import audio_pkg::*;
#(
  parameter int NUM_REQ_P = 3,
  parameter int WIDTH_P   = 24,
  parameter int TIMEOUT_P = 512
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [NUM_REQ_P-1:0]           req_valid_i,
  input  logic [NUM_REQ_P*2*WIDTH_P-1:0] req_data_i,
  output logic [NUM_REQ_P-1:0]           req_ready_o,
  input  logic                           mute_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [WIDTH_P-1:0]             left_o,
  output logic [WIDTH_P-1:0]             right_o,
  output logic [$clog2(NUM_REQ_P)-1:0]   grant_o,
  output logic                           silence_o
);

  localparam int IDX_W = $clog2(NUM_REQ_P);
  localparam int CNT_W = $clog2(TIMEOUT_P);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_P - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ_P - 1);

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [WIDTH_P-1:0] left_q, left_d;
  logic [WIDTH_P-1:0] right_q, right_d;

  logic                 any;
  logic [IDX_W-1:0]     winner;
  logic [NUM_REQ_P-1:0] onehot;
  logic [WIDTH_P-1:0]   req_left  [NUM_REQ_P];
  logic [WIDTH_P-1:0]   req_right [NUM_REQ_P];
  logic                 timeout_hit;

  audio_rr_pick #(
    .NUM_REQ_P (NUM_REQ_P),
    .IDX_W_P   (IDX_W)
  ) u_pick (
    .valid_i  (req_valid_i),
    .ptr_i    (ptr_q),
    .any_o    (any),
    .winner_o (winner),
    .onehot_o (onehot)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ_P; i++) begin
      req_left[i]  = req_data_i[(2*i)*WIDTH_P +: WIDTH_P];
      req_right[i] = req_data_i[(2*i+1)*WIDTH_P +: WIDTH_P];
    end
  end

  // A real request always wins over the timeout in the same cycle.
  assign timeout_hit = (state_q == IDLE) && !any && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    left_d  = left_q;
    right_d = right_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d = SEND;
          cnt_d   = '0;
          grant_d = winner;
          ptr_d   = (winner == IDX_LAST) ? '0 : winner + 1'b1;
          left_d  = mute_i ? '0 : req_left[winner];
          right_d = mute_i ? '0 : req_right[winner];
        end else if (timeout_hit) begin
          state_d = SEND;
          cnt_d   = '0;
          left_d  = '0;
          right_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SEND: begin
        cnt_d = '0;
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign req_ready_o = (state_q == IDLE) ? onehot : '0;
  assign valid_o     = (state_q == SEND);
  assign left_o      = left_q;
  assign right_o     = right_q;
  assign grant_o     = grant_q;
  assign silence_o   = timeout_hit;

endmodule

// File: tb/tb_audio_out_arbiter.sv
// tb/tb_audio_out_arbiter.sv - randomized self-checking bench for audio_out_arbiter
module tb_audio_out_arbiter;

  localparam int N = 3;
  localparam int W = 24;
  localparam int T = 8;

  logic             clk_i = 1'b0;
  logic             reset_n_i = 1'b0;
  logic [N-1:0]     req_valid_i = '0;
  logic [N*2*W-1:0] req_data_i = '0;
  logic [N-1:0]     req_ready_o;
  logic             mute_i = 1'b0;
  logic             valid_o;
  logic             ready_i = 1'b1;
  logic [W-1:0]     left_o, right_o;
  logic [1:0]       grant_o;
  logic             silence_o;

  audio_out_arbiter #(.NUM_REQ_P(N), .WIDTH_P(W), .TIMEOUT_P(T)) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .mute_i      (mute_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .left_o      (left_o),
    .right_o     (right_o),
    .grant_o     (grant_o),
    .silence_o   (silence_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic         rst_drv = 1'b0, rdy_drv = 1'b1, mute_drv = 1'b0;
  logic [N-1:0] pend = '0;
  logic [W-1:0] pl [N];
  logic [W-1:0] pr [N];

  bit           m_busy;
  logic [W-1:0] m_left, m_right;
  int           m_grant, m_ptr, m_idle;
  logic [N-1:0] obs_rdy;
  logic         obs_sil;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_left = '0; m_right = '0;
    m_grant = 0; m_ptr = 0; m_idle = 0;
  endtask

  task automatic step();
    int w;
    logic [N-1:0] exp_rdy;
    logic exp_sil;
    @(negedge clk_i);
    reset_n_i = rst_drv;
    ready_i   = rdy_drv;
    mute_i    = mute_drv;
    for (int i = 0; i < N; i++) begin
      req_valid_i[i] = pend[i];
      req_data_i[2*i*W +: 2*W] = {pr[i], pl[i]};
    end
    #1;
    if (!rst_drv) model_reset();
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    exp_rdy = '0;
    if (!m_busy && w >= 0) exp_rdy[w] = 1'b1;
    exp_sil = !m_busy && (w < 0) && (m_idle == T - 1);
    check_eq("req_ready", 64'(req_ready_o), 64'(exp_rdy));
    check_eq("silence", 64'(silence_o), 64'(exp_sil));
    check_eq("valid", 64'(valid_o), 64'(m_busy));
    check_eq("grant", 64'(grant_o), 64'(m_grant));
    check_eq("left", 64'(left_o), 64'(m_left));
    check_eq("right", 64'(right_o), 64'(m_right));
    obs_rdy = req_ready_o;
    obs_sil = silence_o;
    if (rst_drv) begin
      if (m_busy) begin
        if (rdy_drv) m_busy = 0;
      end else if (w >= 0) begin
        m_busy = 1; m_grant = w; m_ptr = (w + 1) % N; m_idle = 0;
        m_left  = mute_drv ? '0 : pl[w];
        m_right = mute_drv ? '0 : pr[w];
        pend[w] = 1'b0;
      end else if (m_idle == T - 1) begin
        m_busy = 1; m_left = '0; m_right = '0; m_idle = 0;
      end else begin
        m_idle++;
      end
    end
  endtask

  task automatic load(input int i, input logic [W-1:0] l, input logic [W-1:0] r);
    pend[i] = 1'b1; pl[i] = l; pr[i] = r;
  endtask

  initial begin
    int first, second, prev, sils, hit, p;
    for (int i = 0; i < N; i++) begin pl[i] = '0; pr[i] = '0; end
    model_reset();
    repeat (3) step();
    rst_drv = 1'b1;

    first = -1; second = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (obs_sil) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    check_eq("silence_first", 64'(first), 64'(T - 1));
    check_eq("silence_period", 64'(second - first), 64'(T + 1));

    repeat (3) step();
    while (m_busy) step();
    load(1, 24'h123456, 24'hABCDEF);
    step();
    check_eq("single_ready", 64'(obs_rdy), 64'(3'b010));
    step();
    check_eq("single_left", 64'(left_o), 64'(24'h123456));
    check_eq("single_right", 64'(right_o), 64'(24'hABCDEF));
    check_eq("single_grant", 64'(grant_o), 64'(1));

    prev = -1; sils = 0;
    for (int k = 0; k < 18; k++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) load(i, W'($urandom), W'($urandom));
      step();
      if (obs_sil) sils++;
      for (int i = 0; i < N; i++) if (obs_rdy[i]) begin
        if (prev >= 0) check_eq("fair_order", 64'(i), 64'((prev + 1) % N));
        prev = i;
      end
    end
    check_eq("fair_no_silence", 64'(sils), 64'(0));

    pend = '0;
    repeat (2) step();
    load(0, 24'h000111, 24'h000222);
    hit = 0;
    for (int k = 0; k < 4 && !hit; k++) begin step(); if (obs_rdy[0]) hit = 1; end
    check_eq("bp_granted", 64'(hit), 64'(1));
    rdy_drv = 1'b0;
    load(1, 24'h333333, 24'h444444);
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("bp_no_ready", 64'(obs_rdy), 64'(0));
      check_eq("bp_left_hold", 64'(left_o), 64'(24'h000111));
    end
    rdy_drv = 1'b1;
    step();
    step();
    check_eq("bp_next_grant", 64'(obs_rdy), 64'(3'b010));

    while (m_busy) step();
    mute_drv = 1'b1;
    load(2, 24'h7FFFFF, 24'h800000);
    step();
    check_eq("mute_consumed", 64'(obs_rdy), 64'(3'b100));
    step();
    check_eq("mute_left_zero", 64'(left_o), 64'(0));
    mute_drv = 1'b0; rdy_drv = 1'b0;
    load(2, 24'h7FFFFF, 24'h800000);
    step(); step();
    mute_drv = 1'b1;
    repeat (3) step();
    check_eq("mute_late_left", 64'(left_o), 64'(24'h7FFFFF));
    check_eq("mute_late_right", 64'(right_o), 64'(24'h800000));
    mute_drv = 1'b0; rdy_drv = 1'b1;

    pend = '0;
    hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      if (!m_busy && m_idle == T - 1) begin
        load(0, 24'h0A0A0A, 24'h0B0B0B);
        step();
        check_eq("collide_ready", 64'(obs_rdy), 64'(3'b001));
        check_eq("collide_no_sil", 64'(obs_sil), 64'(0));
        hit = 1;
      end else begin
        step();
      end
    end
    check_eq("collide_reached", 64'(hit), 64'(1));
    step();
    check_eq("collide_grant", 64'(grant_o), 64'(0));

    while (m_busy) step();
    rdy_drv = 1'b0;
    load(2, 24'h555555, 24'h666666);
    step(); step();
    reset_n_i = 1'b0;
    #1;
    check_eq("async_rst_valid", 64'(valid_o), 64'(0));
    check_eq("async_rst_left", 64'(left_o), 64'(0));
    rst_drv = 1'b0; pend = '0; rdy_drv = 1'b1;
    repeat (2) step();
    rst_drv = 1'b1;

    for (int seg = 0; seg < 4; seg++) begin
      p = (seg == 0) ? 0 : (seg == 1) ? 5 : (seg == 2) ? 30 : 100;
      for (int k = 0; k < 150; k++) begin
        for (int i = 0; i < N; i++)
          if (!pend[i] && $urandom_range(0, 99) < p) load(i, W'($urandom), W'($urandom));
        rdy_drv  = ($urandom_range(0, 3) != 0);
        mute_drv = ($urandom_range(0, 7) == 0);
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_out_arbiter.md
Name: audio_out_arbiter

Overview:
- Shares the single stereo output channel (the parallel-in/serial-out feeding the I2S2 transmitter) between NUM_REQ_P audio sources, e.g. passthrough, tone generator and tuner beep.
- Grants one whole left/right frame at a time using round-robin order.
- Holds the frame on a valid/ready output until the channel accepts it.
- Injects a zero (silence) frame when no source has data for TIMEOUT_P cycles, so the I2S2 transmitter never starves.

Parameters:
- NUM_REQ_P, 3, number of requesters (2..8)
- WIDTH_P, 24, bits per channel sample (signed two's complement)
- TIMEOUT_P, 512, idle cycles in IDLE before a silence frame is emitted (>=2)

Ports:
- clk_i  input  1  system clock (PLL output)
- reset_n_i  input  1  asynchronous, active-low reset
- req_valid_i  input  NUM_REQ_P  per-requester frame valid
- req_data_i  input  NUM_REQ_P*2*WIDTH_P  requester i occupies bits [(2i+2)*WIDTH_P-1 : 2i*WIDTH_P], packed {right,left} with left in the low half
- req_ready_o  output  NUM_REQ_P  one-hot accept strobe to the granted requester
- mute_i  input  1  when 1, accepted frames are replaced by zeros
- valid_o  output  1  output frame valid
- ready_i  input  1  downstream accepts the frame
- left_o  output  WIDTH_P  left sample
- right_o  output  WIDTH_P  right sample
- grant_o  output  $clog2(NUM_REQ_P)  index of the last requester granted
- silence_o  output  1  one-cycle pulse when a silence frame is loaded

Behaviour:
- Reset (asynchronous, while reset_n_i=0):
  - state=IDLE; valid_o=0; left_o=0; right_o=0.
  - grant_o=0; RR pointer=0, so requester 0 has top priority first; idle counter=0; silence_o=0.
  - Reset asserted mid-frame drops the held frame, with no partial transfer.
- FSM states: IDLE, SEND.
- IDLE:
  - valid_o=0.
  - Winner = first i with req_valid_i[i]=1, scanning from (ptr) upward with wrap modulo NUM_REQ_P.
  - req_ready_o is combinational. It equals onehot(winner) only when in IDLE and any req_valid_i is set; otherwise all zero.
  - On a grant:
    - Latch the winner's left/right into the output register; load zeros instead if mute_i=1.
    - grant_o<=winner; ptr<=(winner+1) mod NUM_REQ_P; counter<=0; go to SEND.
  - With no valid requester:
    - counter increments each cycle.
    - When counter==TIMEOUT_P-1: load a zero frame, pulse silence_o for 1 cycle, counter<=0, go to SEND.
    - ptr and grant_o are unchanged.
  - A real grant always beats the timeout when both occur in the same cycle; no silence pulse is produced.
- SEND:
  - valid_o=1 and data is stable.
  - All req_ready_o=0, and the counter holds at 0.
  - On ready_i=1, go to IDLE next cycle.
- Latency and throughput:
  - A frame accepted at cycle t appears with valid_o=1 at t+1.
  - Minimum of 2 cycles per frame: at most one frame per IDLE→SEND→IDLE round trip.
- Handshake rules:
  - A requester's frame is consumed only on the cycle where req_valid_i[i]&req_ready_o[i]=1.
  - Requesters must hold data stable while valid and not ready.
  - ready_i has no effect in IDLE.
- Width: no arithmetic on samples; they pass through bit-exact, or as zeros when muted or silence.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,0,…, and each requester is served within NUM_REQ_P grants.
- mute_i is sampled only at grant time. A change during SEND does not alter the held frame.

Decomposition:
- Package audio_pkg:
  - localparam sample width 24.
  - packed struct stereo_frame_t {right,left}.
  - FSM enum arb_state_e {IDLE,SEND}.
- Sub-module audio_rr_pick:
  - Purely combinational rotating-priority picker.
  - Inputs: valid vector, ptr.
  - Outputs: any_o, winner index, onehot.
- The top block holds the FSM, counter, output register and pointer.

Test Plan:
- Reset, then no requests with TIMEOUT_P=8 and ready_i=1 → silence_o pulses 8 cycles after reset release (8 cycles in IDLE). valid_o=1 the next cycle with left_o=right_o=0. The pattern repeats every 8+1 IDLE/SEND cycles; grant_o stays 0.
- Single requester 1 valid with left=24'h123456, right=24'hABCDEF, ready_i=1 → req_ready_o=3'b010 for one cycle. Next cycle valid_o=1, left_o=24'h123456, right_o=24'hABCDEF, grant_o=1.
- All three valid continuously with ready_i=1 → grant sequence 0,1,2,0,1,2. Each req_ready_o pulses once per 6 cycles; no silence_o.
- Backpressure: ready_i=0 for 5 cycles after a grant → valid_o stays 1 and data is stable. No req_ready_o asserts during the stall. After ready_i=1, the next grant occurs 1 cycle later.
- mute_i=1 at grant, with requester 2 sending 24'h7FFFFF/24'h800000 → output 0/0 and req_ready_o[2] pulses (frame consumed). Raising mute_i during a held unmuted frame leaves that frame unchanged.
- Timeout collision: requester 0 becomes valid exactly when counter==TIMEOUT_P-1 → requester 0 is granted, silence_o stays 0, counter resets. Asserting reset_n_i=0 during SEND → valid_o drops to 0 immediately (asynchronous).
